// File: rtl/i3c_table_mem.sv
// Shared Depth x Width address-table storage for the I3C controller: two arbitrated
// requesters plus a zeroising sweep. Optional per-lane even parity: I3C_TABLE_MEM_PARITY_EN.
module i3c_table_mem #(
  parameter int unsigned Depth           = 128,
  parameter int unsigned Width           = 64,
  parameter int unsigned DataBitsPerMask = 32,
  localparam int unsigned AddrW          = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  output logic             a_rerror_o,
  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             b_rerror_o,
  input  logic             clear_i,
  output logic             clear_busy_o
);

  if ((Width % DataBitsPerMask) != 0) begin : g_bad_lane
    $fatal(1, "i3c_table_mem: Width must be a multiple of DataBitsPerMask");
  end
  if (Depth < 2) begin : g_bad_depth
    $fatal(1, "i3c_table_mem: Depth must be at least 2");
  end

  localparam logic [AddrW:0]   DepthExt = (AddrW+1)'(Depth);
  localparam logic [AddrW-1:0] LastPtr  = AddrW'(Depth - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_ptr_q, clr_ptr_d;
  logic             prefer_b_q, prefer_b_d;
  logic             clear_busy_q, clear_busy_d;
  logic             clr_we_s;
  logic             a_gnt_s, b_gnt_s;

  logic [Width-1:0] mem_q [Depth];

`ifdef I3C_TABLE_MEM_PARITY_EN
  localparam int unsigned Lanes = Width / DataBitsPerMask;

  function automatic logic [Lanes-1:0] lane_parity(input logic [Width-1:0] word);
    logic [Lanes-1:0] par;
    par = '0;
    for (int l = 0; l < Lanes; l++) begin
      par[l] = ^word[l*DataBitsPerMask +: DataBitsPerMask];
    end
    return par;
  endfunction

  logic [Depth-1:0][Lanes-1:0] par_q;
`endif

  // Sweep/idle sequencing and arbitration; the loser of a contest wins the next one
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    prefer_b_d   = prefer_b_q;
    clr_we_s     = 1'b0;
    a_gnt_s      = 1'b0;
    b_gnt_s      = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_ptr_q == LastPtr) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (a_req_i && b_req_i) begin
          a_gnt_s    = ~prefer_b_q;
          b_gnt_s    = prefer_b_q;
          prefer_b_d = ~prefer_b_q;
        end else begin
          a_gnt_s = a_req_i;
          b_gnt_s = b_req_i;
        end
        if (clear_i) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    clear_busy_d = (state_d == ST_CLEAR);
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_INIT;
      clr_ptr_q    <= '0;
      prefer_b_q   <= 1'b0;
      clear_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      prefer_b_q   <= prefer_b_d;
      clear_busy_q <= clear_busy_d;
    end
  end

  logic [AddrW-1:0] acc_addr_s;
  logic [Width-1:0] acc_wdata_s, acc_wmask_s, merged_s;
  logic             acc_we_s;

  // At most one port is granted per cycle, so a single write path serves both
  always_comb begin
    if (b_gnt_s) begin
      acc_addr_s  = b_addr_i;
      acc_wdata_s = b_wdata_i;
      acc_wmask_s = b_wmask_i;
    end else begin
      acc_addr_s  = a_addr_i;
      acc_wdata_s = a_wdata_i;
      acc_wmask_s = a_wmask_i;
    end
    acc_we_s = ((a_gnt_s & a_write_i) | (b_gnt_s & b_write_i)) &
               ({1'b0, acc_addr_s} < DepthExt);
    merged_s = (mem_q[acc_addr_s] & ~acc_wmask_s) | (acc_wdata_s & acc_wmask_s);
  end

  // Storage is intentionally not reset; only the sweep zeroises it
  always_ff @(posedge clk_i) begin
    if (clr_we_s) begin
      mem_q[clr_ptr_q] <= '0;
`ifdef I3C_TABLE_MEM_PARITY_EN
      par_q[clr_ptr_q] <= '0;
`endif
    end else if (acc_we_s) begin
      mem_q[acc_addr_s] <= merged_s;
`ifdef I3C_TABLE_MEM_PARITY_EN
      par_q[acc_addr_s] <= lane_parity(merged_s);
`endif
    end
  end

  logic             a_addr_ok_s, b_addr_ok_s, a_perr_s, b_perr_s;
  logic [Width-1:0] a_word_s, b_word_s;
  logic             a_rvalid_q, a_rvalid_d, a_rerror_q, a_rerror_d;
  logic             b_rvalid_q, b_rvalid_d, b_rerror_q, b_rerror_d;
  logic [Width-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  // Read lookup; out-of-range entries read as clean zero
  always_comb begin
    a_addr_ok_s = ({1'b0, a_addr_i} < DepthExt);
    b_addr_ok_s = ({1'b0, b_addr_i} < DepthExt);
    a_word_s    = a_addr_ok_s ? mem_q[a_addr_i] : '0;
    b_word_s    = b_addr_ok_s ? mem_q[b_addr_i] : '0;
`ifdef I3C_TABLE_MEM_PARITY_EN
    a_perr_s    = a_addr_ok_s && (lane_parity(mem_q[a_addr_i]) != par_q[a_addr_i]);
    b_perr_s    = b_addr_ok_s && (lane_parity(mem_q[b_addr_i]) != par_q[b_addr_i]);
`else
    a_perr_s    = 1'b0;
    b_perr_s    = 1'b0;
`endif
  end

  // Per-port read response next state; rdata holds between that port's reads
  always_comb begin
    if (a_gnt_s && !a_write_i) begin
      a_rvalid_d = 1'b1;
      a_rdata_d  = a_word_s;
      a_rerror_d = a_perr_s;
    end else begin
      a_rvalid_d = 1'b0;
      a_rdata_d  = a_rdata_q;
      a_rerror_d = 1'b0;
    end
    if (b_gnt_s && !b_write_i) begin
      b_rvalid_d = 1'b1;
      b_rdata_d  = b_word_s;
      b_rerror_d = b_perr_s;
    end else begin
      b_rvalid_d = 1'b0;
      b_rdata_d  = b_rdata_q;
      b_rerror_d = 1'b0;
    end
  end

  // Read response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      a_rerror_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
      b_rerror_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      a_rerror_q <= a_rerror_d;
      b_rvalid_q <= b_rvalid_d;
      b_rdata_q  <= b_rdata_d;
      b_rerror_q <= b_rerror_d;
    end
  end

  assign a_gnt_o      = a_gnt_s;
  assign b_gnt_o      = b_gnt_s;
  assign a_rvalid_o   = a_rvalid_q;
  assign a_rdata_o    = a_rdata_q;
  assign a_rerror_o   = a_rerror_q;
  assign b_rvalid_o   = b_rvalid_q;
  assign b_rdata_o    = b_rdata_q;
  assign b_rerror_o   = b_rerror_q;
  assign clear_busy_o = clear_busy_q;

endmodule

// File: tb/tb_i3c_table_mem.sv
// Randomised scoreboard bench for i3c_table_mem with default parameters (Depth 128, Width 64).
module tb_i3c_table_mem;

  localparam int DEPTH = 128;

  logic        clk_i, rst_ni;
  logic        a_req_i, a_write_i, b_req_i, b_write_i, clear_i;
  logic [6:0]  a_addr_i, b_addr_i;
  logic [63:0] a_wdata_i, a_wmask_i, b_wdata_i, b_wmask_i;
  logic        a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_rerror_o, b_rerror_o, clear_busy_o;
  logic [63:0] a_rdata_o, b_rdata_o;

  i3c_table_mem dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_write_i(a_write_i), .a_addr_i(a_addr_i),
    .a_wdata_i(a_wdata_i), .a_wmask_i(a_wmask_i), .a_gnt_o(a_gnt_o),
    .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o), .a_rerror_o(a_rerror_o),
    .b_req_i(b_req_i), .b_write_i(b_write_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_wmask_i(b_wmask_i), .b_gnt_o(b_gnt_o),
    .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o), .b_rerror_o(b_rerror_o),
    .clear_i(clear_i), .clear_busy_o(clear_busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  exp_t        expq [2][$];
  logic [63:0] hold [2];
  logic [63:0] ref_mem [DEPTH];
  bit          init_pending;
  int          clr_rem;
  bit          last_b;
  int          corrupt_addr;
  int          busy_cnt;
  bit          obs_a_gnt;
  bit [5:0]    pat;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_idle();
    return !init_pending && (clr_rem == 0);
  endfunction

  task automatic model_reset();
    last_b       = 1'b1;
    clr_rem      = 0;
    init_pending = 1'b0;
    corrupt_addr = -1;
    expq[0].delete();
    expq[1].delete();
    hold[0] = '0;
    hold[1] = '0;
  endtask

  task automatic start_sweep();
    clr_rem = DEPTH;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic model_access(input int p, input bit wr, input logic [6:0] addr,
                              input logic [63:0] d, input logic [63:0] m);
    exp_t e;
    if (wr) begin
      ref_mem[addr] = (ref_mem[addr] & ~m) | (d & m);
    end else begin
      e.data = ref_mem[addr];
      e.err  = (int'(addr) == corrupt_addr);
      e.due  = cyc + 1;
      expq[p].push_back(e);
    end
  endtask

  // One clock cycle: check grants/busy against the model at the negedge, then advance it.
  task automatic step();
    bit idle, ga, gb, clr_start;
    @(negedge clk_i);
    idle = model_idle();
    chk("clear_busy", clear_busy_o, (clr_rem > 0));
    if (clear_busy_o) busy_cnt++;
    ga = 1'b0;
    gb = 1'b0;
    if (idle) begin
      if (a_req_i && b_req_i) begin
        ga     = last_b;
        gb     = !last_b;
        last_b = gb;
      end else begin
        ga = a_req_i;
        gb = b_req_i;
      end
    end
    obs_a_gnt = a_gnt_o;
    chk("a_gnt", a_gnt_o, ga);
    chk("b_gnt", b_gnt_o, gb);
    if (ga) model_access(0, a_write_i, a_addr_i, a_wdata_i, a_wmask_i);
    if (gb) model_access(1, b_write_i, b_addr_i, b_wdata_i, b_wmask_i);
    clr_start = idle && clear_i;
    @(posedge clk_i);
    if (init_pending) begin
      init_pending = 1'b0;
      start_sweep();
    end else if (clr_rem > 0) begin
      clr_rem--;
    end else if (clr_start) begin
      start_sweep();
    end
    #1;
  endtask

  function automatic logic [63:0] rand_mask();
    case ($urandom_range(0, 3))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h0000_0000_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic rand_inputs();
    a_req_i   = ($urandom_range(0, 2) != 0);
    a_write_i = ($urandom_range(0, 1) == 1);
    a_addr_i  = 7'($urandom_range(0, DEPTH - 1));
    a_wdata_i = {$urandom(), $urandom()};
    a_wmask_i = rand_mask();
    b_req_i   = ($urandom_range(0, 2) != 0);
    b_write_i = ($urandom_range(0, 1) == 1);
    b_addr_i  = 7'($urandom_range(0, DEPTH - 1));
    b_wdata_i = {$urandom(), $urandom()};
    b_wmask_i = rand_mask();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_a_gnt"}, a_gnt_o, 64'd0);
    chk({tag, "_b_gnt"}, b_gnt_o, 64'd0);
    chk({tag, "_a_rvalid"}, a_rvalid_o, 64'd0);
    chk({tag, "_b_rvalid"}, b_rvalid_o, 64'd0);
    chk({tag, "_a_rdata"}, a_rdata_o, 64'd0);
    chk({tag, "_b_rdata"}, b_rdata_o, 64'd0);
    chk({tag, "_a_rerror"}, a_rerror_o, 64'd0);
    chk({tag, "_b_rerror"}, b_rerror_o, 64'd0);
    chk({tag, "_clear_busy"}, clear_busy_o, 64'd0);
  endtask

  task automatic release_and_sweep(input string tag);
    @(posedge clk_i);
    #1;
    rst_ni       = 1'b1;
    init_pending = 1'b1;
    busy_cnt     = 0;
    while (!model_idle()) step();
    chk({tag, "_sweep_len"}, busy_cnt, 64'd128);
  endtask

  task automatic drive(input int p, input bit req, input bit wr, input logic [6:0] addr,
                       input logic [63:0] d, input logic [63:0] m);
    if (p == 0) begin
      a_req_i = req; a_write_i = wr; a_addr_i = addr; a_wdata_i = d; a_wmask_i = m;
    end else begin
      b_req_i = req; b_write_i = wr; b_addr_i = addr; b_wdata_i = d; b_wmask_i = m;
    end
  endtask

  // Scoreboard monitor: pops one expectation per rvalid, checks holds in between.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int p = 0; p < 2; p++) begin
        logic        rv, re;
        logic [63:0] rd;
        string       pn;
        exp_t        e;
        rv = (p == 0) ? a_rvalid_o : b_rvalid_o;
        re = (p == 0) ? a_rerror_o : b_rerror_o;
        rd = (p == 0) ? a_rdata_o  : b_rdata_o;
        pn = (p == 0) ? "a" : "b";
        if (rv) begin
          if (expq[p].size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_rvalid_unexpected: got 1 expected 0 (cycle %0d)", pn, cyc);
          end else begin
            e = expq[p].pop_front();
            chk({pn, "_rvalid_latency"}, cyc, e.due);
            chk({pn, "_rdata"}, rd, e.data);
            chk({pn, "_rerror"}, re, e.err);
            hold[p] = e.data;
          end
        end else begin
          chk({pn, "_rdata_hold"}, rd, hold[p]);
          chk({pn, "_rerror_idle"}, re, 64'd0);
          if (expq[p].size() > 0 && expq[p][0].due <= cyc) begin
            total++;
            bad++;
            $display("FAIL %s_rvalid_missing: got 0 expected 1 (cycle %0d)", pn, cyc);
            void'(expq[p].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    clear_i = 1'b0;
    drive(0, 1'b1, 1'b0, 7'd127, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs_zero("reset");

    // First sweep with a_req held; the first idle cycle grants the read of entry 127.
    release_and_sweep("por");
    step();
    drive(0, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    step();
    step();

    // Directed full and masked writes with read-after-write on port a.
    drive(0, 1'b1, 1'b1, 7'd5, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(0, 1'b1, 1'b0, 7'd5, 64'd0, 64'd0);
    step();
    drive(0, 1'b1, 1'b1, 7'd5, 64'd0, 64'hFFFF_FFFF_0000_0000);
    step();
    drive(0, 1'b1, 1'b0, 7'd5, 64'd0, 64'd0);
    step();
    drive(0, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    drive(1, 1'b1, 1'b0, 7'd5, 64'd0, 64'd0);
    step();
    drive(1, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    step();

    // Contested reads for six cycles: a, b, a, b, a, b.
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, 1'b0, 7'($urandom_range(0, DEPTH - 1)), 64'd0, 64'd0);
      drive(1, 1'b1, 1'b0, 7'($urandom_range(0, DEPTH - 1)), 64'd0, 64'd0);
      step();
      pat = {pat[4:0], obs_a_gnt};
    end
    chk("contest_pattern", pat, 64'b101010);

    repeat (300) begin
      rand_inputs();
      step();
    end

    // Clear mid-traffic, then a second clear during the sweep that must be ignored.
    rand_inputs();
    clear_i = 1'b1;
    step();
    clear_i  = 1'b0;
    busy_cnt = 0;
    repeat (20) begin
      rand_inputs();
      step();
    end
    rand_inputs();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    while (!model_idle()) begin
      rand_inputs();
      step();
    end
    chk("clear_sweep_len", busy_cnt, 64'd128);
    drive(1, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1'b1, 1'b0, 7'(i), 64'd0, 64'd0);
      step();
    end
    drive(0, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    step();

    // Parity corruption check (only meaningful with parity storage present).
    drive(0, 1'b1, 1'b1, 7'd9, 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
`ifdef I3C_TABLE_MEM_PARITY_EN
    drive(0, 1'b0, 1'b0, 7'd9, 64'd0, 64'd0);
    step();
    force dut.par_q[9][0] = 1'b0;
    corrupt_addr = 9;
`endif
    drive(0, 1'b1, 1'b0, 7'd9, 64'd0, 64'd0);
    step();
    drive(0, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    step();
    step();
`ifdef I3C_TABLE_MEM_PARITY_EN
    release dut.par_q[9][0];
    corrupt_addr = -1;
    drive(0, 1'b1, 1'b1, 7'd9, 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(0, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    step();
`endif

    // Reset asserted at sweep cycle 40, requests held on both ports.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    drive(0, 1'b1, 1'b0, 7'd3, 64'd0, 64'd0);
    drive(1, 1'b1, 1'b0, 7'd4, 64'd0, 64'd0);
    repeat (40) step();
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midsweep_reset");
    model_reset();
    repeat (2) @(posedge clk_i);
    release_and_sweep("post_reset");

    repeat (150) begin
      rand_inputs();
      step();
    end
    drive(0, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 7'd0, 64'd0, 64'd0);
    repeat (3) step();
    chk("drain_a", expq[0].size(), 64'd0);
    chk("drain_b", expq[1].size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
